rv_bus_arb: RTL and testbench

Two-master arbiter sharing the core's single memory bus between the instruction-fetch port and the load/store (memory-stage) port. It grants one outstanding transaction at a time and registers the granted request onto the bus. It returns a one-cycle acknowledge with read data to the winning requester. Data accesses have priority; a starvation counter guarantees fetch progress. The fetch acknowledge feeds the pipeline controller's fetch-stall logic.

---
 rtl/rv_bus_arb_if.sv | 49 ++++
 rtl/rv_bus_arb.sv | 113 +++++++++++
 tb/tb_rv_bus_arb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_bus_arb_if.sv
// Request, response and shared-bus signals of the fetch/data bus arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface rv_bus_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_fetch_req;
    logic [ADDR_W-1:0]     i_fetch_addr;
    logic [DATA_W-1:0]     o_fetch_rdata;
    logic                  o_fetch_ack;

    logic                  i_data_req;
    logic                  i_data_we;
    logic [DATA_W/8-1:0]   i_data_sel;
    logic [ADDR_W-1:0]     i_data_addr;
    logic [DATA_W-1:0]     i_data_wdata;
    logic [DATA_W-1:0]     o_data_rdata;
    logic                  o_data_ack;

    logic                  o_bus_cyc;
    logic                  o_bus_we;
    logic [DATA_W/8-1:0]   o_bus_sel;
    logic [ADDR_W-1:0]     o_bus_addr;
    logic [DATA_W-1:0]     o_bus_wdata;
    logic [DATA_W-1:0]     i_bus_rdata;
    logic                  i_bus_ack;

    logic [1:0]            o_grant;

    modport slave (
        input  i_fetch_req, i_fetch_addr,
        output o_fetch_rdata, o_fetch_ack,
        input  i_data_req, i_data_we, i_data_sel, i_data_addr, i_data_wdata,
        output o_data_rdata, o_data_ack,
        output o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata,
        input  i_bus_rdata, i_bus_ack,
        output o_grant
    );

    modport master (
        output i_fetch_req, i_fetch_addr,
        input  o_fetch_rdata, o_fetch_ack,
        output i_data_req, i_data_we, i_data_sel, i_data_addr, i_data_wdata,
        input  o_data_rdata, o_data_ack,
        input  o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata,
        output i_bus_rdata, i_bus_ack,
        input  o_grant
    );
endinterface

// File: rtl/rv_bus_arb.sv
// Two-master arbiter for the core memory bus: load/store has priority,
// a starvation counter forces a fetch grant; one registered transaction at a time.
module rv_bus_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    rv_bus_arb_if.slave   bif
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_F = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  elig_f, elig_d;
    logic                  take_f, take_d;

    logic                  fetch_ack_q, data_ack_q;
    logic [DATA_W-1:0]     fetch_rdata_q, data_rdata_q;
    logic                  bus_cyc_q, bus_we_q;
    logic [DATA_W/8-1:0]   bus_sel_q;
    logic [ADDR_W-1:0]     bus_addr_q;
    logic [DATA_W-1:0]     bus_wdata_q;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        take_f   = 1'b0;
        take_d   = 1'b0;
        // A requester still holding req in its own ack cycle is not re-granted.
        elig_f   = bif.i_fetch_req & ~fetch_ack_q;
        elig_d   = bif.i_data_req  & ~data_ack_q;
        case (state_q)
            IDLE: begin
                if (elig_f && starve_q == STARVE_LIM) take_f = 1'b1;
                else if (elig_d)                      take_d = 1'b1;
                else if (elig_f)                      take_f = 1'b1;

                if (take_f) begin
                    state_d  = GNT_F;
                    starve_d = '0;
                end else if (take_d) begin
                    state_d = GNT_D;
                    if (elig_f && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
                end
            end
            GNT_F, GNT_D: begin
                if (bif.i_bus_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            fetch_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            bus_cyc_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_sel_q     <= '0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            if (take_f) begin
                bus_cyc_q  <= 1'b1;
                bus_we_q   <= 1'b0;
                bus_sel_q  <= '1;
                bus_addr_q <= bif.i_fetch_addr;
            end else if (take_d) begin
                bus_cyc_q   <= 1'b1;
                bus_we_q    <= bif.i_data_we;
                bus_sel_q   <= bif.i_data_sel;
                bus_addr_q  <= bif.i_data_addr;
                bus_wdata_q <= bif.i_data_wdata;
            end else if (state_q != IDLE && bif.i_bus_ack) begin
                bus_cyc_q <= 1'b0;
                if (state_q == GNT_F) begin
                    fetch_ack_q   <= 1'b1;
                    fetch_rdata_q <= bif.i_bus_rdata;
                end else begin
                    data_ack_q <= 1'b1;
                    if (!bus_we_q) data_rdata_q <= bif.i_bus_rdata;
                end
            end
        end
    end

    assign bif.o_fetch_ack   = fetch_ack_q;
    assign bif.o_fetch_rdata = fetch_rdata_q;
    assign bif.o_data_ack    = data_ack_q;
    assign bif.o_data_rdata  = data_rdata_q;
    assign bif.o_bus_cyc     = bus_cyc_q;
    assign bif.o_bus_we      = bus_we_q;
    assign bif.o_bus_sel     = bus_sel_q;
    assign bif.o_bus_addr    = bus_addr_q;
    assign bif.o_bus_wdata   = bus_wdata_q;
    assign bif.o_grant       = state_q;
endmodule

// File: tb/tb_rv_bus_arb.sv
// Bench for rv_bus_arb: directed scenarios plus randomized requesters and bus,
// all checked cycle by cycle against a transaction-level model of the arbiter.
module tb_rv_bus_arb;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic rst_n;

    rv_bus_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    rv_bus_arb #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .bif(bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Model: who owns the bus (0 none, 1 fetch, 2 data), what was latched at the
    // grant, how many data wins fetch has waited through, and the pending acks.
    int          owner;
    int          starve;
    logic        m_fack, m_dack;
    logic [31:0] m_frd, m_drd, m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_sel;

    task automatic model_reset();
        owner = 0; starve = 0;
        m_fack = 1'b0; m_dack = 1'b0;
        m_frd = '0; m_drd = '0; m_addr = '0; m_wdata = '0;
        m_we = 1'b0; m_sel = '0;
    endtask

    task automatic predict();
        logic ef, ed, nf, nd;
        int win;
        nf = 1'b0; nd = 1'b0; win = 0;
        if (owner == 0) begin
            ef = bif.i_fetch_req && !m_fack;
            ed = bif.i_data_req && !m_dack;
            if (ef && starve == STARVE_MAX) win = 1;
            else if (ed)                    win = 2;
            else if (ef)                    win = 1;
            if (win == 1) begin
                starve = 0;
                m_addr = bif.i_fetch_addr; m_we = 1'b0; m_sel = 4'hF;
            end else if (win == 2) begin
                if (ef && starve < STARVE_MAX) starve++;
                m_addr = bif.i_data_addr; m_we = bif.i_data_we;
                m_sel = bif.i_data_sel; m_wdata = bif.i_data_wdata;
            end
            owner = win;
        end else if (bif.i_bus_ack) begin
            if (owner == 1) begin
                nf = 1'b1; m_frd = bif.i_bus_rdata;
            end else begin
                nd = 1'b1;
                if (!m_we) m_drd = bif.i_bus_rdata;
            end
            owner = 0;
        end
        m_fack = nf; m_dack = nd;
    endtask

    task automatic compare(input string tag);
        check({tag, "_cyc"},    32'(bif.o_bus_cyc),     32'(owner != 0));
        check({tag, "_grant"},  32'(bif.o_grant),       32'(owner));
        check({tag, "_fack"},   32'(bif.o_fetch_ack),   32'(m_fack));
        check({tag, "_dack"},   32'(bif.o_data_ack),    32'(m_dack));
        check({tag, "_frdata"}, bif.o_fetch_rdata,      m_frd);
        check({tag, "_drdata"}, bif.o_data_rdata,       m_drd);
        if (owner != 0) begin
            check({tag, "_addr"}, bif.o_bus_addr,       m_addr);
            check({tag, "_we"},   32'(bif.o_bus_we),    32'(m_we));
            check({tag, "_sel"},  32'(bif.o_bus_sel),   32'(m_sel));
        end
        if (owner == 2) check({tag, "_wdata"}, bif.o_bus_wdata, m_wdata);
    endtask

    // Inputs are set at the negedge before calling; outputs checked at the next negedge.
    task automatic step(input string tag);
        predict();
        @(posedge clk);
        @(negedge clk);
        compare(tag);
    endtask

    logic f_act, f_gnt, d_act, d_gnt;

    initial begin
        rst_n = 1'b0;
        bif.i_fetch_req = 1'b0; bif.i_fetch_addr = '0;
        bif.i_data_req = 1'b0; bif.i_data_we = 1'b0; bif.i_data_sel = '0;
        bif.i_data_addr = '0; bif.i_data_wdata = '0;
        bif.i_bus_rdata = '0; bif.i_bus_ack = 1'b0;
        model_reset();

        @(negedge clk);
        check("rst_cyc",    32'(bif.o_bus_cyc),   32'd0);
        check("rst_we",     32'(bif.o_bus_we),    32'd0);
        check("rst_sel",    32'(bif.o_bus_sel),   32'd0);
        check("rst_addr",   bif.o_bus_addr,       32'd0);
        check("rst_wdata",  bif.o_bus_wdata,      32'd0);
        check("rst_fack",   32'(bif.o_fetch_ack), 32'd0);
        check("rst_dack",   32'(bif.o_data_ack),  32'd0);
        check("rst_frdata", bif.o_fetch_rdata,    32'd0);
        check("rst_drdata", bif.o_data_rdata,     32'd0);
        check("rst_grant",  32'(bif.o_grant),     32'd0);
        rst_n = 1'b1;
        step("idle");

        // Single fetch, zero-wait bus.
        bif.i_fetch_req = 1'b1; bif.i_fetch_addr = 32'h100;
        step("t1");
        check("t1_cyc_c1",   32'(bif.o_bus_cyc), 32'd1);
        check("t1_grant_c1", 32'(bif.o_grant),   32'd1);
        check("t1_addr_c1",  bif.o_bus_addr,     32'h100);
        bif.i_bus_ack = 1'b1; bif.i_bus_rdata = 32'hDEADBEEF;
        step("t1");
        check("t1_fack_c2",  32'(bif.o_fetch_ack), 32'd1);
        check("t1_rdata_c2", bif.o_fetch_rdata,    32'hDEADBEEF);
        check("t1_cyc_c2",   32'(bif.o_bus_cyc),   32'd0);
        bif.i_fetch_req = 1'b0; bif.i_bus_ack = 1'b0;
        step("t1");
        check("t1_fack_c3",  32'(bif.o_fetch_ack), 32'd0);

        // Store with 3 wait states; requester inputs change under the grant.
        bif.i_data_req = 1'b1; bif.i_data_we = 1'b1; bif.i_data_addr = 32'h2000;
        bif.i_data_wdata = 32'h12345678; bif.i_data_sel = 4'b0011;
        step("t2");
        for (int i = 0; i < 4; i++) begin
            check("t2_cyc",   32'(bif.o_bus_cyc), 32'd1);
            check("t2_we",    32'(bif.o_bus_we),  32'd1);
            check("t2_sel",   32'(bif.o_bus_sel), 32'b0011);
            check("t2_addr",  bif.o_bus_addr,     32'h2000);
            check("t2_wdata", bif.o_bus_wdata,    32'h12345678);
            bif.i_data_addr = 32'hFFFF_FFF0; bif.i_data_wdata = '0;
            bif.i_data_sel = 4'hF; bif.i_data_we = 1'b0;
            bif.i_bus_ack = (i == 3); bif.i_bus_rdata = 32'hBAD0_0000;
            step("t2");
        end
        check("t2_dack",   32'(bif.o_data_ack), 32'd1);
        check("t2_drdata", bif.o_data_rdata,    32'd0);
        bif.i_data_req = 1'b0; bif.i_bus_ack = 1'b0;
        step("t2");
        check("t2_dack_off", 32'(bif.o_data_ack), 32'd0);

        // Both held continuously: data first, then alternating via the ack mask.
        bif.i_fetch_req = 1'b1; bif.i_fetch_addr = 32'h300;
        bif.i_data_req = 1'b1; bif.i_data_we = 1'b0; bif.i_data_addr = 32'h400;
        bif.i_bus_ack = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            bif.i_bus_rdata = 32'hA5A5_0000 + 32'(c);
            step("t3");
            check("t3_grant", 32'(bif.o_grant),
                  (c % 2 == 0) ? 32'd0 : ((c % 4 == 1) ? 32'd2 : 32'd1));
        end
        bif.i_fetch_req = 1'b0; bif.i_data_req = 1'b0; bif.i_bus_ack = 1'b0;
        step("t3");

        // Req held through its ack cycle is not re-granted.
        bif.i_fetch_req = 1'b1; bif.i_fetch_addr = 32'h500; bif.i_bus_ack = 1'b1;
        step("t4");
        step("t4");
        check("t4_ack", 32'(bif.o_fetch_ack), 32'd1);
        step("t4");
        check("t4_nogrant", 32'(bif.o_bus_cyc), 32'd0);
        bif.i_fetch_req = 1'b0;
        step("t4");
        check("t4_idle", 32'(bif.o_bus_cyc), 32'd0);
        bif.i_bus_ack = 1'b0; bif.i_fetch_req = 1'b1; bif.i_fetch_addr = 32'h504;
        step("t4");
        check("t4_regrant", 32'(bif.o_bus_cyc), 32'd1);
        check("t4_addr",    bif.o_bus_addr,     32'h504);
        bif.i_bus_ack = 1'b1;
        step("t4");
        bif.i_fetch_req = 1'b0; bif.i_bus_ack = 1'b0;
        step("t4");

        // Async reset in the middle of a data grant.
        bif.i_data_req = 1'b1; bif.i_data_we = 1'b0; bif.i_data_addr = 32'h600;
        step("t5");
        step("t5");
        check("t5_cyc_pre", 32'(bif.o_bus_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_cyc_async",   32'(bif.o_bus_cyc),  32'd0);
        check("t5_grant_async", 32'(bif.o_grant),    32'd0);
        model_reset();
        bif.i_data_req = 1'b0; bif.i_bus_ack = 1'b1; bif.i_bus_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        rst_n = 1'b1;
        step("t5");
        check("t5_no_dack", 32'(bif.o_data_ack), 32'd0);
        bif.i_bus_ack = 1'b0;
        step("t5");

        // Fetch flushed mid-grant, data pending behind it.
        bif.i_fetch_req = 1'b1; bif.i_fetch_addr = 32'h700;
        step("t6");
        bif.i_fetch_req = 1'b0;
        bif.i_data_req = 1'b1; bif.i_data_we = 1'b1; bif.i_data_addr = 32'h800;
        bif.i_data_wdata = 32'hCAFE_F00D; bif.i_data_sel = 4'hF;
        step("t6");
        check("t6_grant_hold", 32'(bif.o_grant), 32'd1);
        bif.i_bus_ack = 1'b1; bif.i_bus_rdata = 32'h7777_7777;
        step("t6");
        check("t6_fack",       32'(bif.o_fetch_ack), 32'd1);
        check("t6_idle_gap",   32'(bif.o_grant),     32'd0);
        bif.i_bus_ack = 1'b0;
        step("t6");
        check("t6_grant_d",    32'(bif.o_grant),     32'd2);
        check("t6_fack_once",  32'(bif.o_fetch_ack), 32'd0);
        check("t6_addr",       bif.o_bus_addr,       32'h800);
        bif.i_bus_ack = 1'b1;
        step("t6");
        bif.i_data_req = 1'b0; bif.i_bus_ack = 1'b0;
        step("t6");

        // Randomized traffic: requesters hold until ack, may flush after grant.
        f_act = 1'b0; f_gnt = 1'b0; d_act = 1'b0; d_gnt = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (f_act && owner == 1) f_gnt = 1'b1;
            if (m_fack) begin f_act = 1'b0; f_gnt = 1'b0; end
            if (!f_act) begin
                if ($urandom_range(2) == 0) begin
                    f_act = 1'b1; bif.i_fetch_req = 1'b1; bif.i_fetch_addr = $urandom;
                end else begin
                    bif.i_fetch_req = 1'b0;
                end
            end else if (f_gnt) begin
                bif.i_fetch_addr = $urandom;
                if ($urandom_range(7) == 0) bif.i_fetch_req = 1'b0;
            end

            if (d_act && owner == 2) d_gnt = 1'b1;
            if (m_dack) begin d_act = 1'b0; d_gnt = 1'b0; end
            if (!d_act) begin
                if ($urandom_range(2) == 0) begin
                    d_act = 1'b1; bif.i_data_req = 1'b1;
                    bif.i_data_we = 1'($urandom_range(1)); bif.i_data_sel = 4'($urandom);
                    bif.i_data_addr = $urandom; bif.i_data_wdata = $urandom;
                end else begin
                    bif.i_data_req = 1'b0;
                end
            end else if (d_gnt) begin
                bif.i_data_we = 1'($urandom_range(1)); bif.i_data_sel = 4'($urandom);
                bif.i_data_addr = $urandom; bif.i_data_wdata = $urandom;
                if ($urandom_range(7) == 0) bif.i_data_req = 1'b0;
            end

            bif.i_bus_ack = ($urandom_range(2) == 0);
            bif.i_bus_rdata = $urandom;
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
